// File: rtl/nim_cfg_pkg.sv
// Shared types for the NIM input configuration controller: per-channel
// config record, register offsets, FSM states and the readback word helper.
package nim_cfg_pkg;

   typedef struct packed {
      logic [7:0]  delay;
      logic [63:0] stretch;
      logic        invert;
      logic        enable;
   } ch_cfg_t;

   localparam logic [1:0] REG_DELAY  = 2'd0;
   localparam logic [1:0] REG_STR_LO = 2'd1;
   localparam logic [1:0] REG_STR_HI = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      BLANK = 2'd2
   } cfg_state_t;

   // Software-visible 32-bit view of one register of a channel record.
   function automatic logic [31:0] cfg_word(input ch_cfg_t c, input logic [1:0] r);
      logic [31:0] w;
      w = '0;
      case (r)
         REG_DELAY:  w = {24'd0, c.delay};
         REG_STR_LO: w = c.stretch[31:0];
         REG_STR_HI: w = c.stretch[63:32];
         default:    w = {30'd0, c.enable, c.invert};
      endcase
      return w;
   endfunction

endpackage

// File: rtl/nim_cfg_blank_timer.sv
// Down-counter that times the post-commit blanking window. Resets loaded,
// so the block blanks straight out of reset without an APPLY.
module nim_cfg_blank_timer #(
   parameter  int BLANK_CYCLES = 160,
   localparam int CNT_W        = $clog2(BLANK_CYCLES)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic dec_i,
   output logic done_o
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(BLANK_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = LOAD_VAL;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt_q <= LOAD_VAL;
      else
         cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/nim_input_cfg_ctrl.sv
// Shadow/active configuration bank for NUM_CH NIM input channels with
// commit, channel reset and output blanking. NIM_CFG_READBACK_EN adds a shadow readback port.
module nim_input_cfg_ctrl
   import nim_cfg_pkg::*;
#(
   parameter  int NUM_CH       = 4,
   parameter  int BLANK_CYCLES = 160,
   localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int ADDR_W       = CH_W + 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cfg_wr,
   input  logic [ADDR_W-1:0]        cfg_addr,
   input  logic [31:0]              cfg_wdata,
   input  logic                     commit,
   output logic                     busy,
   output logic [NUM_CH-1:0][7:0]   ch_delay,
   output logic [NUM_CH-1:0][63:0]  ch_stretch,
   output logic [NUM_CH-1:0]        ch_invert,
   output logic                     ch_reset,
   output logic [NUM_CH-1:0]        ch_out_en
`ifdef NIM_CFG_READBACK_EN
   ,
   input  logic                     cfg_rd,
   output logic [31:0]              cfg_rdata,
   output logic                     cfg_rvalid
`endif
);

   ch_cfg_t          shadow_q [NUM_CH];
   ch_cfg_t          shadow_d [NUM_CH];
   ch_cfg_t          active_q [NUM_CH];
   cfg_state_t       state_q;
   logic             busy_q;
   logic             ch_reset_q;
   logic [NUM_CH-1:0] out_en_q;
   logic [NUM_CH-1:0] active_en;
   logic [CH_W-1:0]  addr_ch;
   logic [1:0]       addr_reg;
   logic             t_load, t_dec, t_done;

   assign addr_ch  = cfg_addr[ADDR_W-1:2];
   assign addr_reg = cfg_addr[1:0];

   // Channel match by loop index: addresses beyond NUM_CH match nothing.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         shadow_d[i] = shadow_q[i];
         if (cfg_wr && (addr_ch == CH_W'(i))) begin
            case (addr_reg)
               REG_DELAY:  shadow_d[i].delay          = cfg_wdata[7:0];
               REG_STR_LO: shadow_d[i].stretch[31:0]  = cfg_wdata;
               REG_STR_HI: shadow_d[i].stretch[63:32] = cfg_wdata;
               default: begin
                  shadow_d[i].invert = cfg_wdata[0];
                  shadow_d[i].enable = cfg_wdata[1];
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++)
            shadow_q[i] <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++)
         active_en[i] = active_q[i].enable;
   end

   // Outputs are computed alongside the state transition so they stay registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= BLANK;
         busy_q     <= 1'b1;
         ch_reset_q <= 1'b1;
         out_en_q   <= '0;
         for (int i = 0; i < NUM_CH; i++)
            active_q[i] <= '0;
      end else begin
         ch_reset_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (commit) begin
                  state_q    <= APPLY;
                  busy_q     <= 1'b1;
                  ch_reset_q <= 1'b1;
                  out_en_q   <= '0;
               end
            end
            APPLY: begin
               for (int i = 0; i < NUM_CH; i++)
                  active_q[i] <= shadow_q[i];
               state_q <= BLANK;
            end
            BLANK: begin
               if (commit) begin
                  state_q    <= APPLY;
                  ch_reset_q <= 1'b1;
               end else if (t_done) begin
                  state_q  <= IDLE;
                  busy_q   <= 1'b0;
                  out_en_q <= active_en;
               end
            end
            default: begin
               state_q  <= BLANK;
               busy_q   <= 1'b1;
               out_en_q <= '0;
            end
         endcase
      end
   end

   assign t_load = (state_q == APPLY);
   assign t_dec  = (state_q == BLANK);

   nim_cfg_blank_timer #(
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_blank_timer (
      .clk_i  (clk),
      .rst_i  (reset),
      .load_i (t_load),
      .dec_i  (t_dec),
      .done_o (t_done)
   );

   assign busy      = busy_q;
   assign ch_reset  = ch_reset_q;
   assign ch_out_en = out_en_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_out
      assign ch_delay[g]   = active_q[g].delay;
      assign ch_stretch[g] = active_q[g].stretch;
      assign ch_invert[g]  = active_q[g].invert;
   end

`ifdef NIM_CFG_READBACK_EN
   logic [31:0] rdata_d, rdata_q;
   logic        rvalid_q;

   // Reads shadow_q, so a same-cycle write to the same word returns the old value.
   always_comb begin
      rdata_d = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (addr_ch == CH_W'(i))
            rdata_d = cfg_word(shadow_q[i], addr_reg);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= cfg_rd;
         if (cfg_rd)
            rdata_q <= rdata_d;
      end
   end

   assign cfg_rdata  = rdata_q;
   assign cfg_rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_nim_input_cfg_ctrl.sv
// Scoreboard bench for nim_input_cfg_ctrl: expected active snapshots are queued
// at commit time and compared when blanking ends.
module tb_nim_input_cfg_ctrl;

   localparam int NUM_CH = 4;
   localparam int BLANK  = 160;
   localparam int AW     = 4;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic                    cfg_wr = 1'b0;
   logic [AW-1:0]           cfg_addr = '0;
   logic [31:0]             cfg_wdata = '0;
   logic                    commit = 1'b0;
   logic                    busy;
   logic [NUM_CH-1:0][7:0]  ch_delay;
   logic [NUM_CH-1:0][63:0] ch_stretch;
   logic [NUM_CH-1:0]       ch_invert;
   logic                    ch_reset;
   logic [NUM_CH-1:0]       ch_out_en;
`ifdef NIM_CFG_READBACK_EN
   logic                    cfg_rd = 1'b0;
   logic [31:0]             cfg_rdata;
   logic                    cfg_rvalid;
`endif

   always #5 clk = ~clk;

   nim_input_cfg_ctrl #(.NUM_CH(NUM_CH), .BLANK_CYCLES(BLANK)) dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_wr     (cfg_wr),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .commit     (commit),
      .busy       (busy),
      .ch_delay   (ch_delay),
      .ch_stretch (ch_stretch),
      .ch_invert  (ch_invert),
      .ch_reset   (ch_reset),
      .ch_out_en  (ch_out_en)
`ifdef NIM_CFG_READBACK_EN
      ,
      .cfg_rd     (cfg_rd),
      .cfg_rdata  (cfg_rdata),
      .cfg_rvalid (cfg_rvalid)
`endif
   );

   typedef struct {
      logic [NUM_CH-1:0][7:0]  d;
      logic [NUM_CH-1:0][63:0] s;
      logic [NUM_CH-1:0]       inv;
      logic [NUM_CH-1:0]       en;
   } snap_t;

   snap_t m_sh;
   snap_t m_act;
   snap_t exp_q[$];
   int    n_chk = 0;
   int    n_err = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h", tag, act, exp);
      end
   endtask

   task automatic model_clear();
      m_sh.d = '0; m_sh.s = '0; m_sh.inv = '0; m_sh.en = '0;
      m_act = m_sh;
   endtask

   task automatic drive_wr(input int ch, input int r, input logic [31:0] d);
      cfg_wr    = 1'b1;
      cfg_addr  = AW'(ch * 4 + r);
      cfg_wdata = d;
      case (r)
         0: m_sh.d[ch] = d[7:0];
         1: m_sh.s[ch][31:0] = d;
         2: m_sh.s[ch][63:32] = d;
         default: begin m_sh.inv[ch] = d[0]; m_sh.en[ch] = d[1]; end
      endcase
   endtask

   // All stimulus tasks start and end at a falling edge.
   task automatic wr(input int ch, input int r, input logic [31:0] d);
      drive_wr(ch, r, d);
      @(negedge clk);
      cfg_wr = 1'b0;
   endtask

   task automatic chk_snap(input string tag, input snap_t e);
      for (int i = 0; i < NUM_CH; i++) begin
         check($sformatf("%s_dly%0d", tag, i), 64'(ch_delay[i]), 64'(e.d[i]));
         check($sformatf("%s_str%0d", tag, i), ch_stretch[i], e.s[i]);
      end
      check($sformatf("%s_inv", tag), 64'(ch_invert), 64'(e.inv));
      check($sformatf("%s_oen", tag), 64'(ch_out_en), 64'(e.en));
   endtask

   task automatic commit_seq(input string tag,
                             input bit w0, input int c0, input int r0, input logic [31:0] d0,
                             input bit w1, input int c1, input int r1, input logic [31:0] d1,
                             input int restart_at);
      int  busy_n, rst_n, cyc;
      bit  oe_bad;
      snap_t e;
      commit = 1'b1;
      if (w0) drive_wr(c0, r0, d0);
      exp_q.push_back(m_sh);
      @(negedge clk);
      commit = 1'b0;
      cfg_wr = 1'b0;
      if (w1) drive_wr(c1, r1, d1);
      check({tag, "_rst_rise"}, 64'(ch_reset), 64'd1);
      busy_n = 0; rst_n = 0; cyc = 0; oe_bad = 1'b0;
      while (busy && cyc < 1000) begin
         busy_n++;
         if (ch_reset) rst_n++;
         if (ch_out_en != '0) oe_bad = 1'b1;
         if (restart_at != 0 && busy_n == restart_at) begin
            commit = 1'b1;
            exp_q.delete();
            exp_q.push_back(m_sh);
         end else begin
            commit = 1'b0;
         end
         @(negedge clk);
         cfg_wr = 1'b0;
         cyc++;
      end
      commit = 1'b0;
      check({tag, "_timeout"}, 64'(cyc >= 1000), 64'd0);
      check({tag, "_busy_len"}, 64'(busy_n), 64'(restart_at + BLANK + 1));
      check({tag, "_rst_pulses"}, 64'(rst_n), (restart_at != 0) ? 64'd2 : 64'd1);
      check({tag, "_oen_blanked"}, 64'(oe_bad), 64'd0);
      check({tag, "_sb_nonempty"}, 64'(exp_q.size()), 64'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         m_act = e;
         chk_snap(tag, e);
      end
   endtask

   task automatic wait_blank(input string tag, input int want);
      int n;
      n = 0;
      while (busy && n < 1000) begin
         n++;
         @(negedge clk);
      end
      check({tag, "_busy_len"}, 64'(n), 64'(want));
   endtask

`ifdef NIM_CFG_READBACK_EN
   logic [31:0] rd_q[$];

   function automatic logic [31:0] model_word(input int ch, input int r);
      case (r)
         0: return {24'd0, m_sh.d[ch]};
         1: return m_sh.s[ch][31:0];
         2: return m_sh.s[ch][63:32];
         default: return {30'd0, m_sh.en[ch], m_sh.inv[ch]};
      endcase
   endfunction

   task automatic rd(input string tag, input int ch, input int r, input bit also_wr, input logic [31:0] d);
      cfg_rd   = 1'b1;
      cfg_addr = AW'(ch * 4 + r);
      rd_q.push_back(model_word(ch, r));
      if (also_wr) drive_wr(ch, r, d);
      @(negedge clk);
      cfg_rd = 1'b0;
      cfg_wr = 1'b0;
      check({tag, "_rvalid"}, 64'(cfg_rvalid), 64'd1);
      check({tag, "_rdata"}, 64'(cfg_rdata), 64'(rd_q.pop_front()));
      @(negedge clk);
      check({tag, "_rvalid_pulse"}, 64'(cfg_rvalid), 64'd0);
   endtask
`endif

   initial begin
      model_clear();

      // Reset state and post-reset blanking.
      @(negedge clk);
      check("rst_ch_reset", 64'(ch_reset), 64'd1);
      check("rst_busy", 64'(busy), 64'd1);
      check("rst_oen", 64'(ch_out_en), 64'd0);
      reset = 1'b0;
      wait_blank("rst_release", BLANK);
      check("rst_ch_reset_low", 64'(ch_reset), 64'd0);
      chk_snap("rst_idle", m_act);

      // Configure ch2; unused wdata bits must be ignored.
      wr(2, 0, 32'hFFFF_FF25);
      wr(2, 1, 32'h0000_0010);
      wr(2, 2, 32'h0000_0001);
      wr(2, 3, 32'h0000_0003);
      commit_seq("c_ch2", 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Shadow-only write must not reach the active bank.
      wr(1, 0, 32'h0000_0010);
      repeat (40) @(negedge clk);
      check("noc_dly1", 64'(ch_delay[1]), 64'(m_act.d[1]));
      check("noc_oen", 64'(ch_out_en), 64'(m_act.en));

      // Recommit at BLANK count 50 (busy cycle 111).
      commit_seq("c_restart", 0, 0, 0, 0, 0, 0, 0, 0, 111);

      // Write with commit is applied; write during APPLY is not.
      commit_seq("c_samecyc", 1, 0, 3, 32'h0000_0002, 1, 3, 3, 32'h0000_0003, 0);
      repeat (5) @(negedge clk);
      check("apply_wr_ch3_oen", 64'(ch_out_en[3]), 64'd0);

`ifdef NIM_CFG_READBACK_EN
      rd("rb_ch2_r0", 2, 0, 0, 0);
      rd("rb_ch2_r2", 2, 2, 0, 0);
      rd("rb_ch3_ctrl", 3, 3, 0, 0);
      rd("rb_rw_same", 1, 0, 1, 32'h0000_00AB);
      rd("rb_after_wr", 1, 0, 0, 0);
`endif

      // Reset in the middle of a blanking window.
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
      repeat (30) @(negedge clk);
      check("mid_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      #1;
      model_clear();
      check("mid_rst_ch_reset", 64'(ch_reset), 64'd1);
      check("mid_rst_busy", 64'(busy), 64'd1);
      chk_snap("mid_rst", m_act);
      @(negedge clk);
      reset = 1'b0;
      wait_blank("mid_release", BLANK);
      chk_snap("mid_idle", m_act);
`ifdef NIM_CFG_READBACK_EN
      rd("rb_cleared", 2, 0, 0, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/nim_input_cfg_ctrl.md
Name: nim_input_cfg_ctrl

Overview:
Configuration controller for a bank of NUM_CH NIM input channels. Each channel has a delay (8 bit), a stretch (64 bit), an invert bit and an enable bit.
- Software writes per-channel settings into shadow registers through a simple word-addressed write/read port.
- A commit pulse copies all shadow registers into the active registers in one cycle and pulses the channel reset.
- Channel outputs are then blanked until the delay lines have flushed.
- Sits between the slow-control register bus and the NIM_input instances; the top level ANDs each channel trig_out with ch_out_en.

Parameters:
NUM_CH, 4, number of NIM input channels (1..16)
BLANK_CYCLES, 160, cycles outputs stay disabled after commit or reset; must be >= 129 (maximum delay-line depth 128 + 1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cfg_wr  in  1  write strobe, one word per cycle
cfg_addr  in  ADDR_W  word address = {channel, reg[1:0]}; ADDR_W = $clog2(NUM_CH)+2 (minimum 3)
cfg_wdata  in  32  write data
commit  in  1  single-cycle pulse: apply shadow configuration
busy  out  1  high while in APPLY or BLANK
ch_delay  out  NUM_CH x 8  active delay per channel
ch_stretch  out  NUM_CH x 64  active stretch per channel
ch_invert  out  NUM_CH  active invert per channel
ch_reset  out  1  reset to all channel instances
ch_out_en  out  NUM_CH  per-channel output gate

Behaviour:
- Register map (reg field):
  - 0: delay = wdata[7:0]
  - 1: stretch[31:0]
  - 2: stretch[63:32]
  - 3: invert = wdata[0], enable = wdata[1]
- Unused wdata bits are ignored.
- Writes to a channel index >= NUM_CH are dropped.
- Writes always land in the shadow registers, in any state, at the clock edge where cfg_wr is high. Active registers are unaffected by writes.
- FSM states:
  - IDLE: busy=0, ch_reset=0, ch_out_en = active enable bits. commit=1 -> APPLY.
  - APPLY (1 cycle): active <= shadow as sampled at the start of the cycle; ch_reset=1; counter loaded with BLANK_CYCLES-1; -> BLANK. A write in the APPLY cycle itself stays in the shadow only and is not applied.
  - BLANK: ch_out_en=0, ch_reset=0, counter decrements. At counter=0 -> IDLE. commit=1 -> APPLY (restarts the sequence).
- Commit and write in the same IDLE cycle: the write is captured in the shadow at that edge, and the following APPLY copies it.
- All outputs are registered.
- Commit to usable output:
  - ch_reset rises 1 cycle after the commit cycle.
  - ch_out_en rises 1 + BLANK_CYCLES cycles after the commit cycle (busy high for BLANK_CYCLES+1 cycles).
- Asynchronous reset:
  - shadow and active registers cleared (delay=0, stretch=0, invert=0, enable=0);
  - ch_reset=1 while reset is asserted;
  - busy=1; ch_out_en=0;
  - state=BLANK with counter=BLANK_CYCLES-1.
  After reset release, the block blanks for BLANK_CYCLES cycles, then enters IDLE with all channels disabled.
- Reset mid-BLANK or mid-APPLY: restart from the reset state; no partial configuration survives.
- Counter width is $clog2(BLANK_CYCLES). No wrap: the counter is only decremented in BLANK while nonzero.

Optional Feature:
NIM_CFG_READBACK_EN
- Defined: adds ports cfg_rd (in, 1), cfg_rdata (out, 32) and cfg_rvalid (out, 1).
- cfg_rdata returns the shadow word at cfg_addr with 1-cycle latency; cfg_rvalid is a 1-cycle pulse.
- Unused bits and out-of-range channels read 0.
- A read and a write to the same address in the same cycle return the old value.
- Undefined: those ports are absent and no readback mux is built.

Decomposition:
- Package nim_cfg_pkg holds:
  - typedef ch_cfg_t struct {delay[7:0], stretch[63:0], invert, enable};
  - register offset localparams REG_DELAY=0, REG_STR_LO=1, REG_STR_HI=2, REG_CTRL=3;
  - enum cfg_state_t {IDLE, APPLY, BLANK}.
- Shadow and active storage are arrays of ch_cfg_t.
- One natural sub-module: nim_cfg_blank_timer (load, decrement, done), instantiated once.

Test Plan:
- Reset release -> busy=1 and ch_out_en=0 for 160 cycles, then busy=0; ch_out_en=4'b0000; all active fields 0.
- Write ch2: delay=0x25, stretch=0x0000_0001_0000_0010, ctrl=0x3; commit -> ch_reset high exactly 1 cycle after commit; ch_delay[2]=0x25, ch_stretch[2]=0x1_0000_0010, ch_invert[2]=1; ch_out_en=4'b0100 exactly 161 cycles after commit.
- Write ch1 delay=0x10 with no commit -> active ch_delay[1] stays 0 indefinitely.
- Commit at BLANK count 50 -> second ch_reset pulse; busy stays high a further 161 cycles; ch_out_en stays 0 throughout.
- Write ch0 ctrl=0x2 in the same cycle as commit -> ch_out_en[0]=1 after blanking; a write to ch3 during the APPLY cycle is not applied.
- Reset asserted mid-BLANK after a configured commit -> active registers cleared immediately; ch_reset=1 during reset. With NIM_CFG_READBACK_EN defined: read of ch2 reg0 returns 0x25 one cycle later with cfg_rvalid=1.
